// File: rtl/pipe_hazard_ctrl.sv
// Issue/hazard controller beside ID: scoreboard of in-flight writes, stall/flush/halt.
// Optional PIPE_HAZARD_FWD_EN: forward non-load results, stall only on load-use.
module pipe_hazard_ctrl #(
  parameter int REG_AW   = 4,
  parameter int WB_DEPTH = 3,
  parameter int CNT_W    = $clog2(WB_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs0,
  input  logic              id_re0,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic              id_re1,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_hlt,
  input  logic              br_taken,
  output logic              issue,
  output logic              stall,
  output logic              flush,
  output logic              hlt_done,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic [CNT_W-1:0]  fwd_sel0,
  output logic [CNT_W-1:0]  fwd_sel1
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e              state_q;
  logic                hlt_done_q;

  logic [WB_DEPTH-1:0] v_q;
  logic [WB_DEPTH-1:0] ld_q;
  logic [REG_AW-1:0]   rd_q [WB_DEPTH];
  logic                push_d;

  logic [REG_AW-1:0]   rs [2];
  logic [1:0]          re_w;
  logic [1:0]          match;
  logic [1:0]          haz;
  logic [CNT_W-1:0]    mslot [2];
  logic                hazard;
  logic [CNT_W-1:0]    cnt;

  assign rs[0] = id_rs0;
  assign rs[1] = id_rs1;
  assign re_w  = {id_re1, id_re0};

  // Youngest match wins: scan oldest-to-youngest so lower slots override.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      match[s] = 1'b0;
      mslot[s] = '0;
      for (int k = WB_DEPTH - 2; k >= 0; k--) begin
        if (re_w[s] && (rs[s] != '0) && v_q[k] &&
            (rd_q[k] == rs[s])) begin
          match[s] = 1'b1;
          mslot[s] = CNT_W'(k);
        end
      end
    end
  end

`ifdef PIPE_HAZARD_FWD_EN
  logic [CNT_W-1:0] fwd [2];

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      haz[s] = match[s] && (mslot[s] == '0) && ld_q[0];
      fwd[s] = match[s] ? (mslot[s] + CNT_W'(1)) : '0;
    end
  end

  assign fwd_sel0 = fwd[0];
  assign fwd_sel1 = fwd[1];
`else
  logic unused_nofwd;

  assign haz          = match;
  assign fwd_sel0     = '0;
  assign fwd_sel1     = '0;
  assign unused_nofwd = ^{ld_q, mslot[0], mslot[1]};
`endif

  assign hazard = |haz;

  always_comb begin
    cnt = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      cnt = cnt + CNT_W'(v_q[k]);
    end
  end

  assign pend_cnt = cnt;
  assign hlt_done = hlt_done_q;

  always_comb begin
    issue = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          flush = br_taken;
          stall = id_valid & hazard & ~br_taken;
          issue = id_valid & ~hazard & ~br_taken;
        end
        DRAIN, HALTED: begin
          stall = 1'b1;
        end
        default: begin
          stall = 1'b0;
        end
      endcase
    end
  end

  assign push_d = issue & id_we & (id_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int k = 0; k < WB_DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q     <= {v_q[WB_DEPTH-2:0], push_d};
      ld_q    <= {ld_q[WB_DEPTH-2:0], id_load};
      rd_q[0] <= id_rd;
      for (int k = 1; k < WB_DEPTH; k++) begin
        rd_q[k] <= rd_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      hlt_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (issue && id_hlt) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (cnt == '0) begin
            state_q    <= HALTED;
            hlt_done_q <= 1'b1;
          end
        end
        HALTED: begin
          hlt_done_q <= 1'b1;
        end
        default: begin
          state_q    <= RUN;
          hlt_done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: timestamped write-log model plus directed anchors.
module tb_pipe_hazard_ctrl;

  localparam int AW = 4;
  localparam int WB = 3;
  localparam int CW = $clog2(WB + 1);
`ifdef PIPE_HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs0;
  logic          id_re0;
  logic [AW-1:0] id_rs1;
  logic          id_re1;
  logic [AW-1:0] id_rd;
  logic          id_we;
  logic          id_load;
  logic          id_hlt;
  logic          br_taken;
  logic          issue;
  logic          stall;
  logic          flush;
  logic          hlt_done;
  logic [CW-1:0] pend_cnt;
  logic [CW-1:0] fwd_sel0;
  logic [CW-1:0] fwd_sel1;

  pipe_hazard_ctrl #(
    .REG_AW  (AW),
    .WB_DEPTH(WB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .id_valid(id_valid),
    .id_rs0  (id_rs0),
    .id_re0  (id_re0),
    .id_rs1  (id_rs1),
    .id_re1  (id_re1),
    .id_rd   (id_rd),
    .id_we   (id_we),
    .id_load (id_load),
    .id_hlt  (id_hlt),
    .br_taken(br_taken),
    .issue   (issue),
    .stall   (stall),
    .flush   (flush),
    .hlt_done(hlt_done),
    .pend_cnt(pend_cnt),
    .fwd_sel0(fwd_sel0),
    .fwd_sel1(fwd_sel1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: each accepted write is logged with the cycle it issued in.
  // In cycle n it sits (n - c - 1) stages past ID; gone once that reaches WB.
  typedef struct {
    int          c;
    logic [AW-1:0] rd;
    bit          ld;
  } wr_t;

  wr_t mq[$];
  bit  m_drain = 1'b0;
  bit  m_halt  = 1'b0;

  always @(negedge clk) begin : model
    int            pend;
    int            age;
    int            best;
    bit            bld;
    bit            hz_any;
    bit            run;
    bit            e_issue;
    bit            e_stall;
    bit            e_flush;
    int            fs [2];
    logic [AW-1:0] src [2];
    bit            rdn [2];
    wr_t           nw;

    while (mq.size() > 0 && (cyc - mq[0].c - 1) >= WB) void'(mq.pop_front());

    pend = 0;
    foreach (mq[i]) begin
      age = cyc - mq[i].c - 1;
      if (age >= 0 && age < WB) pend++;
    end

    src[0] = id_rs0; src[1] = id_rs1;
    rdn[0] = id_re0; rdn[1] = id_re1;
    hz_any = 1'b0;
    for (int s = 0; s < 2; s++) begin
      best = -1;
      bld  = 1'b0;
      foreach (mq[i]) begin
        age = cyc - mq[i].c - 1;
        if (rdn[s] && src[s] != 0 && age >= 0 && age <= WB - 2 &&
            mq[i].rd == src[s] && (best < 0 || age < best)) begin
          best = age;
          bld  = mq[i].ld;
        end
      end
      if (FWD) hz_any |= (best == 0) && bld;
      else     hz_any |= (best >= 0);
      fs[s] = (FWD && best >= 0) ? best + 1 : 0;
    end

    run = !m_drain && !m_halt;
    e_issue = 1'b0; e_stall = 1'b0; e_flush = 1'b0;
    if (!rst) begin
      if (run) begin
        e_flush = br_taken;
        e_stall = id_valid && hz_any && !br_taken;
        e_issue = id_valid && !hz_any && !br_taken;
      end else begin
        e_stall = 1'b1;
      end
    end

    if (cyc >= 1) begin
      chk("m_issue", issue, e_issue);
      chk("m_stall", stall, e_stall);
      chk("m_flush", flush, e_flush);
      chk("m_hlt_done", hlt_done, m_halt);
      chk("m_pend_cnt", pend_cnt, pend);
      chk("m_fwd_sel0", fwd_sel0, fs[0]);
      chk("m_fwd_sel1", fwd_sel1, fs[1]);
    end

    if (rst) begin
      mq.delete();
      m_drain = 1'b0;
      m_halt  = 1'b0;
    end else begin
      if (e_issue && id_we && id_rd != 0) begin
        nw.c = cyc; nw.rd = id_rd; nw.ld = id_load;
        mq.push_back(nw);
      end
      if (run && e_issue && id_hlt) begin
        m_drain = 1'b1;
      end else if (m_drain && pend == 0) begin
        m_drain = 1'b0;
        m_halt  = 1'b1;
      end
    end
  end

  task automatic set_in(bit v, logic [AW-1:0] rs0, bit re0,
                        logic [AW-1:0] rs1, bit re1, logic [AW-1:0] rd,
                        bit we, bit ld, bit hlt, bit br);
    id_valid = v;   id_rs0  = rs0; id_re0 = re0;
    id_rs1   = rs1; id_re1  = re1; id_rd  = rd;
    id_we    = we;  id_load = ld;  id_hlt = hlt;
    br_taken = br;
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); chk("rst_issue0", issue, 0); to_next();
    to_neg(); chk("rst_issue1", issue, 0); to_next();
    rst = 1'b0;

    to_neg();
    chk("first_issue", issue, 1); chk("first_stall", stall, 0);
    chk("first_pend", pend_cnt, 0); chk("first_hlt_done", hlt_done, 0);
    to_next();

    // ADD R3, then a reader of R3
    set_in(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    to_neg(); chk("add_issue", issue, 1); to_next();
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    to_neg();
    chk("raw_stall1", stall, FWD ? 0 : 1);
    chk("raw_fwd1", fwd_sel0, FWD ? 1 : 0);
    chk("raw_pend1", pend_cnt, 1);
    to_next();
    to_neg(); chk("raw_stall2", stall, FWD ? 0 : 1); chk("raw_pend2", pend_cnt, 1); to_next();
    to_neg();
    chk("raw_issue3", issue, 1); chk("raw_stall3", stall, 0);
    chk("raw_pend3", pend_cnt, 1);
    to_next();

    // LW R3, then a reader of R3
    set_in(1, 0, 0, 0, 0, 3, 1, 1, 0, 0);
    to_neg(); chk("lw_issue", issue, 1); chk("lw_pend", pend_cnt, 0); to_next();
    set_in(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); chk("lu_stall1", stall, 1); chk("lu_issue1", issue, 0); to_next();
    to_neg();
    chk("lu_stall2", stall, FWD ? 0 : 1);
    chk("lu_fwd2", fwd_sel0, FWD ? 2 : 0);
    to_next();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); chk("idle_stall", stall, 0); chk("idle_issue", issue, 0); to_next();

    // R0 is never tracked
    set_in(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    to_neg(); chk("r0w_issue", issue, 1); to_next();
    set_in(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    to_neg(); chk("r0r_stall", stall, 0); chk("r0r_pend", pend_cnt, 0); to_next();

    // branch squashes a hazarding HLT
    set_in(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    to_neg(); chk("r5_issue", issue, 1); to_next();
    set_in(1, 5, 1, 0, 0, 0, 0, 0, 1, 1);
    to_neg();
    chk("br_flush", flush, 1); chk("br_stall", stall, 0); chk("br_issue", issue, 0);
    to_next();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); chk("br_pend", pend_cnt, 1); chk("br_run", stall, 0); to_next();

    // HLT with two pending writes
    set_in(1, 0, 0, 0, 0, 6, 1, 0, 0, 0); to_neg(); to_next();
    set_in(1, 0, 0, 0, 0, 7, 1, 0, 0, 0); to_neg(); to_next();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    to_neg(); chk("hlt_issue", issue, 1); to_next();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); chk("dr_stall", stall, 1); chk("dr_pend2", pend_cnt, 2); chk("dr_issue", issue, 0); to_next();
    to_neg(); chk("dr_pend1", pend_cnt, 1); to_next();
    to_neg(); chk("dr_pend0", pend_cnt, 0); chk("dr_hd0", hlt_done, 0); to_next();
    to_neg(); chk("halted_hd", hlt_done, 1); chk("halted_stall", stall, 1); to_next();
    rst = 1'b1; to_neg(); to_next(); rst = 1'b0;
    to_neg(); chk("post_rst_hd", hlt_done, 0); chk("post_rst_issue", issue, 1); to_next();

    // reset in the middle of a drain
    set_in(1, 0, 0, 0, 0, 2, 1, 0, 0, 0); to_neg(); to_next();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 1, 0); to_neg(); to_next();
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    to_neg(); chk("dr2_stall", stall, 1); chk("dr2_pend", pend_cnt, 1); to_next();
    rst = 1'b1; to_neg(); to_next(); rst = 1'b0;
    to_neg();
    chk("dr2_rst_pend", pend_cnt, 0); chk("dr2_rst_hd", hlt_done, 0);
    chk("dr2_rst_issue", issue, 1); chk("dr2_rst_stall", stall, 0);
    to_next();

    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 3) != 0,
             AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             AW'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
             $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0,
             $urandom_range(0, 7) == 0);
      to_next();
    end
    rst = 1'b0;
    to_neg();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Issue/hazard controller for the pipelined successor of the single-cycle CPU core.
- Sits beside the ID stage. Tracks in-flight register writes in a WB_DEPTH-deep scoreboard shift register.
- Decides issue, stall or flush each cycle, and sequences halt so it only completes after the pipeline has drained.
- Register-address width, pipeline depth and forwarding mode are parametrised. The single-cycle core needs none of this.

Parameters:
- REG_AW, 4: register address width; R0 is hardwired zero.
- WB_DEPTH, 3: number of stages from issue (exit ID) to writeback; must be ≥2.
- CNT_W, $clog2(WB_DEPTH+1): width of pend_cnt and the fwd_sel outputs.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs0  in  REG_AW  source 0 address.
- id_re0  in  1  source 0 is read.
- id_rs1  in  REG_AW  source 1 address.
- id_re1  in  1  source 1 is read.
- id_rd  in  REG_AW  destination address.
- id_we  in  1  instruction writes id_rd.
- id_load  in  1  instruction is a load (result ready at end of MEM).
- id_hlt  in  1  instruction is HLT.
- br_taken  in  1  EX resolved a taken branch/JR this cycle.
- issue  out  1  ID instruction advances this cycle.
- stall  out  1  hold PC and IF/ID.
- flush  out  1  squash IF/ID contents.
- hlt_done  out  1  core halted, pipeline empty.
- pend_cnt  out  CNT_W  count of valid scoreboard entries.
- fwd_sel0  out  CNT_W  forward select for source 0 (FWD_EN only).
- fwd_sel1  out  CNT_W  forward select for source 1 (FWD_EN only).

Behaviour:
- Scoreboard: slots 0..WB_DEPTH-1, each holding {v, rd, load}.
  - Every edge, all slots shift up by one; slot WB_DEPTH-1 retires.
  - Slot 0 is loaded with {1, id_rd, id_load} when issue & id_we & id_rd≠0; otherwise a bubble (v=0).
- Hazard check:
  - A source hits if its read enable is high and its address equals rd of a valid entry in slots 0..WB_DEPTH-2.
  - Slot WB_DEPTH-1 is excluded because the rf writes before it reads in the same cycle.
  - Address 0 never hits.
- FSM states RUN, DRAIN, HALTED. Reset → RUN.
  - RUN: stall = id_valid & hazard & ~br_taken; flush = br_taken; issue = id_valid & ~hazard & ~br_taken.
  - RUN: issue & id_hlt → DRAIN.
  - DRAIN: issue=0, stall=1, flush=0. pend_cnt==0 at an edge → HALTED.
  - HALTED: hlt_done=1, stall=1, issue=0. Remains until rst.
- All outputs are combinational from the current state and scoreboard plus inputs; no added latency. hlt_done is registered (state decode).
- br_taken has priority over everything:
  - It wins over a hazard (no stall, flush).
  - It wins over id_hlt in the same cycle (the HLT is squashed and the FSM stays in RUN).
  - Scoreboard entries already issued are older than the branch and are not cleared.
- Reset values: all scoreboard v=0, state RUN, pend_cnt=0, hlt_done=0, fwd_sel0/1=0. With id_valid=0: issue=0, stall=0, flush=0.
- rst mid-DRAIN or in HALTED → RUN with an empty scoreboard on the next cycle.
- pend_cnt counts v bits in all WB_DEPTH slots and saturates naturally at WB_DEPTH.

Optional Feature:
- Macro: PIPE_HAZARD_FWD_EN.
- Defined:
  - A non-load hit in any slot is not a hazard.
  - A load hit in slot 0 is a hazard (load-use, exactly 1 stall).
  - fwd_selN = k+1, where k is the lowest-index (youngest) matching valid slot; 0 means use the rf.
- Undefined: every hit stalls, and fwd_sel0/1 are tied to 0.

Test Plan:
1. Reset: hold rst 2 cycles with id_valid=1 → issue=0 during reset; afterwards pend_cnt=0, hlt_done=0, and first instruction (no hits) issue=1, stall=0.
2. No FWD, WB_DEPTH=3: issue ADD R3 (we), then ID reads R3 on re0 → stall=1 for exactly 2 cycles, issue=1 on 3rd; pend_cnt sequence 1,1,1.
3. FWD_EN: ADD R3 then dependent → stall=0, fwd_sel0=1. LW R3 then dependent → stall=1 for 1 cycle, then issue with fwd_sel0=2.
4. Write to R0 then read R0 → no scoreboard entry (pend_cnt stays 0), stall=0.
5. br_taken=1 while ID holds a hazarding HLT → flush=1, stall=0, issue=0, FSM stays RUN, slot 0 bubble.
6. HLT issued with 2 pending writes → stall=1, hlt_done rises after pend_cnt reaches 0 (3 cycles); rst during DRAIN → RUN, pend_cnt=0, hlt_done=0 next cycle.
